// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR word scheduler and any standalone LFSR
// block: word width, default feedback mask and seed, the scheduler FSM
// state type, and the single-step Galois LFSR function.
package lfsr_pkg;

  localparam int LFSR_W = 32;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS_DEFAULT = 32'h80200003;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 32'h00000001;

  typedef enum logic {
    WARMUP = 1'b0,
    SERVE  = 1'b1
  } sched_state_e;

  // One Galois step: shift right, fold the mask in when a one falls out.
  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] state,
    input logic [LFSR_W-1:0] taps
  );
    logic [LFSR_W-1:0] shifted;
    shifted = state >> 1;
    return state[0] ? (shifted ^ taps) : shifted;
  endfunction

endpackage

// File: rtl/lfsr_rr_sched_rr_arbiter.sv
// Round-robin arbiter. Picks the first asserted request at or after ptr,
// searching upward modulo N_REQ. Purely combinational.
// Ports:
//   req    - request vector
//   ptr    - highest-priority index for this cycle
//   en     - when low, no grant is issued
//   gnt    - one-hot grant (all zero if no winner)
//   winner - index of the granted requester (0 when gnt is zero)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] winner
);

  int               idx;
  logic [PTR_W-1:0] sel;
  logic             found;

  // Walk the requesters starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = PTR_W'(idx);
      if (en && !found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        winner   = sel;
      end
    end
  end

endmodule

// File: rtl/lfsr_rr_sched.sv
// LFSR word scheduler: owns a 32-bit Galois LFSR and hands its words out to
// N_REQ requesters in round-robin order. After reset or a reseed the LFSR is
// stepped WARMUP_STEPS times before any word is served. Every grant consumes
// the current word and advances the LFSR by one step.
// Ports:
//   clk, reset_n  - rising-edge clock, asynchronous active-low reset
//   req_i         - level requests, one word per granted cycle
//   gnt_o         - one-hot combinational grant; req & gnt = transfer
//   rnd_o         - current LFSR word, valid whenever gnt_o != 0
//   seed_we_i     - load seed_i this cycle (beats any request)
//   seed_i        - new seed; zero is replaced by SEED_DEFAULT
//   busy_o        - high while warming up
//   served_cnt_o  - words delivered since reset, wraps at 16 bits
module lfsr_rr_sched
  import lfsr_pkg::*;
#(
  parameter int                N_REQ        = 4,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_TAPS_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_SEED_DEFAULT,
  parameter int                WARMUP_STEPS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  req_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic [LFSR_W-1:0] rnd_o,
  input  logic              seed_we_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              busy_o,
  output logic [15:0]       served_cnt_o
);

  localparam int               PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);
  localparam logic [15:0]      WARM_LAST  = (WARMUP_STEPS > 0) ? 16'(WARMUP_STEPS - 1) : 16'd0;
  // With no warm-up configured, reset and reseed land straight in SERVE.
  localparam sched_state_e     START_STATE = (WARMUP_STEPS == 0) ? SERVE : WARMUP;

  sched_state_e      state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]       warm_cnt_q, warm_cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]       served_q, served_d;

  logic              arb_en;
  logic [N_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]  arb_winner;

  // Grants only in SERVE, never alongside a seed load, and never while reset
  // is asserted (the grant path is combinational).
  assign arb_en = reset_n && (state_q == SERVE) && !seed_we_i;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req    (req_i),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .winner (arb_winner)
  );

  assign gnt_o        = arb_gnt;
  assign rnd_o        = lfsr_q;
  assign busy_o       = (state_q != SERVE);
  assign served_cnt_o = served_q;

  // Next-state logic. A seed load overrides everything else; a zero seed is
  // swapped for SEED_DEFAULT so the LFSR can never lock up at zero.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    served_d   = served_q;

    if (seed_we_i) begin
      lfsr_d     = (seed_i == '0) ? SEED_DEFAULT : seed_i;
      state_d    = START_STATE;
      warm_cnt_d = '0;
    end else begin
      unique case (state_q)
        WARMUP: begin
          lfsr_d     = lfsr_step(lfsr_q, TAPS);
          warm_cnt_d = warm_cnt_q + 16'd1;
          if (warm_cnt_q == WARM_LAST) state_d = SERVE;
        end
        SERVE: begin
          if (arb_gnt != '0) begin
            lfsr_d   = lfsr_step(lfsr_q, TAPS);
            rr_ptr_d = (arb_winner == PTR_LAST) ? '0 : arb_winner + PTR_W'(1);
            served_d = served_q + 16'd1;
          end
        end
        default: state_d = START_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= START_STATE;
      lfsr_q     <= SEED_DEFAULT;
      warm_cnt_q <= '0;
      rr_ptr_q   <= '0;
      served_q   <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      warm_cnt_q <= warm_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      served_q   <= served_d;
    end
  end

endmodule

// File: doc/lfsr_rr_sched.md
Name: lfsr_rr_sched

Overview:
Owns a 32-bit Galois LFSR and shares its output words among N_REQ requesters using round-robin arbitration. After reset or reseed, it runs a fixed number of warm-up steps before serving words. Each accepted grant consumes exactly one LFSR word and advances the LFSR by one step. It sits between the random source and its consumers, for example scramblers and test-pattern engines.

Parameters:
N_REQ, 4, number of requesters (2..8)
TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1)
SEED_DEFAULT, 32'h00000001, reset seed; also substituted for a zero seed
WARMUP_STEPS, 16, LFSR steps discarded after reset/reseed (0 allowed)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_i  in  N_REQ  level request; one word per cycle while high and granted
gnt_o  out  N_REQ  one-hot grant, combinational; req&gnt in a cycle = transfer
rnd_o  out  32  current LFSR word, valid in any cycle where gnt_o != 0
seed_we_i  in  1  load seed_i this cycle
seed_i  in  32  new seed
busy_o  out  1  high while not in SERVE (warm-up in progress)
served_cnt_o  out  16  words delivered since reset; wraps 0xFFFF->0

Behaviour:
- LFSR step: next = state[0] ? ((state>>1) ^ TAPS) : (state>>1). All 32 bits unsigned.
- FSM states are WARMUP and SERVE.
- Async reset (reset_n=0):
  - state=SEED_DEFAULT, FSM=WARMUP, warm_cnt=0, rr_ptr=0, served_cnt_o=0.
  - gnt_o=0, busy_o=1, rnd_o=state.
  - If WARMUP_STEPS=0, FSM resets directly to SERVE with busy_o=0.
- WARMUP:
  - LFSR steps every cycle; warm_cnt increments.
  - On the cycle with warm_cnt==WARMUP_STEPS-1, FSM moves to SERVE (that step still occurs).
  - gnt_o=0 throughout; requests are ignored, not queued.
- SERVE:
  - If any req_i bit is set and seed_we_i=0, the winner is the first set bit at or after rr_ptr, searching upward modulo N_REQ.
  - gnt_o is one-hot for the winner; rnd_o is the pre-step state.
  - On the clock edge: LFSR steps, rr_ptr=(winner+1) mod N_REQ, served_cnt_o increments.
  - No request: LFSR holds, rr_ptr holds.
- Fairness:
  - All requesters held high -> grants rotate 0,1,..,N_REQ-1,0.
  - A lone requester is granted every cycle; zero-cycle latency from req to gnt.
- Seed load (seed_we_i=1, any state):
  - gnt_o=0 that cycle; seed load takes priority over any request.
  - Next state = (seed_i==0) ? SEED_DEFAULT : seed_i. This prevents LFSR lock-up.
  - FSM moves to WARMUP (or to SERVE if WARMUP_STEPS=0), warm_cnt=0, busy_o=1.
  - rr_ptr and served_cnt_o are preserved.
- Reseed mid-warm-up restarts the warm-up count.
- Reset mid-operation returns all registers to their reset values immediately.
- LFSR state is never 0: TAPS has bit 31 set and the state is seeded nonzero.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W=32, default TAPS and SEED_DEFAULT constants.
  - The FSM state enum {WARMUP, SERVE}.
  - The function lfsr_step(state, taps), shared with the standalone lfsr block.
- One sub-module: rr_arbiter (N_REQ param). Inputs: req, ptr, en. Outputs: one-hot gnt, winner index.

Test Plan:
1. WARMUP_STEPS=2, reset low 5 cycles then high:
   - busy_o=1 for 2 cycles, then 0.
   - req_i=0001 held: rnd_o on successive grants = 0xC0300002, 0x60180001, 0xB02C0003.
   - served_cnt_o counts 1,2,3.
2. SERVE, req_i=1111 held 8 cycles:
   - gnt_o sequence 0001,0010,0100,1000,0001,0010,0100,1000.
   - Each granted word equals lfsr_step of the previous word.
3. Grant to requester 1 (rr_ptr=2), then req_i=0011:
   - next grant goes to requester 0 (wrap-around), then to requester 1.
4. WARMUP_STEPS=0, seed_we_i=1, seed_i=0 together with req_i=0001:
   - gnt_o=0 that cycle.
   - Next cycle rnd_o=0x00000001 with a grant, then 0x80200003.
5. Reseed with 0x12345678 during cycle 1 of a WARMUP_STEPS=16 warm-up:
   - busy_o stays high for 16 further cycles.
   - The first word equals 16 steps of 0x12345678 (bench reference model).
6. reset_n pulsed low mid-SERVE while req_i=1111:
   - gnt_o drops to 0 asynchronously.
   - served_cnt_o=0, and after warm-up the sequence restarts from SEED_DEFAULT.
